// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters
// ALU codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not A, 6 A<<1, 7 signed A<B
module ALU #(
  parameter int W  = 6,
  parameter int FW = 3
) (
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [FW-1:0] fxn,
  output logic [W-1:0]  X
);
  always_comb begin
    case (fxn)
      3'd0:    X = A + B;
      3'd1:    X = A - B;
      3'd2:    X = A & B;
      3'd3:    X = A | B;
      3'd4:    X = A ^ B;
      3'd5:    X = ~A;
      3'd6:    X = {A[W-2:0], 1'b0};
      default: X = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int W  = 6,
  parameter int FW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic [FW-1:0] req0_fxn,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic [FW-1:0] req1_fxn,
  output logic          rsp0_valid,
  output logic [W-1:0]  rsp0_x,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  output logic [W-1:0]  rsp1_x,
  input  logic          rsp1_ready,
  output logic          busy,
  output logic [7:0]    ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t        r_state;
  logic          r_last, r_id, r_v0, r_v1;
  logic [W-1:0]  r_a, r_b, r_x0, r_x1;
  logic [FW-1:0] r_fxn;
  logic [7:0]    r_ops;
  logic          w_idle, w_g0, w_g1, w_rsp_rdy;
  logic [W-1:0]  w_x;
  // readies are held low while reset is asserted, even though the state already reads IDLE
  assign w_idle     = (r_state == IDLE) & ~reset;
  assign w_g1       = req1_valid & (~req0_valid | ~r_last);
  assign w_g0       = req0_valid & ~w_g1;
  assign req0_ready = w_idle & w_g0;
  assign req1_ready = w_idle & w_g1;
  assign w_rsp_rdy  = r_id ? rsp1_ready : rsp0_ready;
  assign rsp0_valid = r_v0;
  assign rsp1_valid = r_v1;
  assign rsp0_x     = r_x0;
  assign rsp1_x     = r_x1;
  assign busy       = r_state != IDLE;
  assign ops_done   = r_ops;
  ALU #(.W(W), .FW(FW)) u_alu (.A(r_a), .B(r_b), .fxn(r_fxn), .X(w_x));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_fxn   <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_ops   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_g0 | w_g1) begin
          r_a     <= w_g1 ? req1_a : req0_a;
          r_b     <= w_g1 ? req1_b : req0_b;
          r_fxn   <= w_g1 ? req1_fxn : req0_fxn;
          r_id    <= w_g1;
          r_state <= EXEC;
        end
        EXEC: begin
          if (r_id) begin
            r_x1 <= w_x;
            r_v1 <= 1'b1;
          end else begin
            r_x0 <= w_x;
            r_v0 <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: if (w_rsp_rdy) begin
          r_v0    <= 1'b0;
          r_v1    <= 1'b0;
          r_last  <= r_id;
          r_ops   <= r_ops + 8'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a queue scoreboard popped by an independent response monitor
module tb_alu_arbiter;
  logic       clk = 0, reset = 1;
  logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [5:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_fxn = 0, req1_fxn = 0;
  logic       rsp0_valid, rsp1_valid, rsp0_ready = 1, rsp1_ready = 1, busy;
  logic [5:0] rsp0_x, rsp1_x;
  logic [7:0] ops_done;
  int         checks = 0, errors = 0, cyc = 0, v0_cnt = 0, v1_cnt = 0, acc0 = 0, acc1 = 0;
  logic [5:0] q0[$], q1[$];
  int         glog[$];

  alu_arbiter #(.W(6), .FW(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fxn(req0_fxn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fxn(req1_fxn),
    .rsp0_valid(rsp0_valid), .rsp0_x(rsp0_x), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_x(rsp1_x), .rsp1_ready(rsp1_ready),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (rsp0_valid) v0_cnt++;
    if (rsp1_valid) v1_cnt++;
    if (rsp0_valid && rsp0_ready) begin
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rsp0 unexpected: x=%0d", rsp0_x);
      end else chk("rsp0_x", rsp0_x, q0.pop_front());
    end
    if (rsp1_valid && rsp1_ready) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rsp1 unexpected: x=%0d", rsp1_x);
      end else chk("rsp1_x", rsp1_x, q1.pop_front());
    end
  end

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    q0.delete();
    q1.delete();
    glog.delete();
  endtask

  task automatic do_req(input int id, input logic [5:0] a, input logic [5:0] b, input logic [2:0] f,
                        input logic [5:0] exp);
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_fxn = f; req0_valid = 1;
    end else begin
      req1_a = a; req1_b = b; req1_fxn = f; req1_valid = 1;
    end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        if (id == 0) begin
          q0.push_back(exp); acc0 = cyc;
        end else begin
          q1.push_back(exp); acc1 = cyc;
        end
        glog.push_back(id);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 0; else req1_valid = 0;
        return;
      end
    end
    errors++;
    $display("FAIL req%0d accept timeout", id);
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 1;
    #2;
    chk("reset req0_ready", req0_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset ops_done", ops_done, 0);
    chk("reset rsp0_valid", rsp0_valid, 0);
    chk("reset rsp0_x", rsp0_x, 0);
    req0_valid = 0;
    do_reset();

    // single op: 4+3
    v0_cnt = 0; v1_cnt = 0;
    do_req(0, 6'd4, 6'd3, 3'd0, 6'd7);
    chk("single busy in EXEC", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("single rsp0_valid cycles", v0_cnt, 1);
    chk("single rsp1_valid cycles", v1_cnt, 0);
    chk("single ops_done", ops_done, 1);
    chk("single busy after", busy, 0);
    chk("single q0 drained", q0.size(), 0);

    // tie from reset: -5-(-5)=0, 20|48=52
    do_reset();
    fork
      do_req(0, 6'b111011, 6'b111011, 3'd1, 6'd0);
      do_req(1, 6'd20, 6'b110000, 3'd3, 6'd52);
    join
    repeat (3) @(posedge clk);
    #1;
    chk("tie first grant", glog[0], 0);
    chk("tie second grant", glog[1], 1);
    chk("tie ready spacing", acc1 - acc0, 3);
    chk("tie ops_done", ops_done, 2);
    chk("tie q drained", q0.size() + q1.size(), 0);

    // repeated tie: 3+4=7, 9-6=3
    do_reset();
    fork
      begin repeat (4) do_req(0, 6'd3, 6'd4, 3'd0, 6'd7); end
      begin repeat (4) do_req(1, 6'd9, 6'd6, 3'd1, 6'd3); end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("rr grant count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr order", glog[i], i % 2);
    chk("rr ops_done", ops_done, 8);

    // backpressure: 27^29=6, with req0 (1+1=2) waiting
    rsp1_ready = 0;
    do_req(1, 6'd27, 6'd29, 3'd4, 6'd6);
    req0_a = 1; req0_b = 1; req0_fxn = 0; req0_valid = 1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rsp1_valid", rsp1_valid, 1);
      chk("bp rsp1_x", rsp1_x, 6);
      chk("bp req readies", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk);
    #1 rsp1_ready = 1;
    @(posedge clk);
    #1;
    chk("bp rsp1_valid cleared", rsp1_valid, 0);
    chk("bp ops_done", ops_done, 9);
    do_req(0, 6'd1, 6'd1, 3'd0, 6'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("bp waiter ops_done", ops_done, 10);

    // async reset mid-RESP: 5&1=1
    rsp0_ready = 0;
    do_req(0, 6'd5, 6'd1, 3'd2, 6'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mid rsp0_valid before reset", rsp0_valid, 1);
    #3 reset = 1;
    #1;
    chk("mid reset rsp0_valid", rsp0_valid, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset ops_done", ops_done, 0);
    chk("mid reset rsp0_x", rsp0_x, 0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rsp0_ready = 1;
    req0_a = 5; req0_b = 1; req0_fxn = 2; req0_valid = 1;
    #1;
    chk("post reset req0_ready", req0_ready, 1);
    do_req(0, 6'd5, 6'd1, 3'd2, 6'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("post reset ops_done", ops_done, 1);

    // counter wrap: 2<<1=4
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_req(0, 6'd2, 6'd3, 3'd6, 6'd4);
      repeat (2) @(posedge clk);
      #1;
      if (i == 254) chk("wrap ops_done 255", ops_done, 255);
      if (i == 255) chk("wrap ops_done 0", ops_done, 0);
    end
    chk("final q drained", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
